// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: per-frame scan of the enabled electrode channels.
// Walks the latched channel mask in ascending order, settles the analog mux,
// fires the SAR ADC and delivers each result as a one-cycle sample strobe.
// A programmable period counter paces frame starts; ticks that land while a
// frame is still running are dropped and flagged as overrun.
// Optional build macro: ADC_SEQ_TIMEOUT_EN adds a conversion watchdog that
// abandons a channel whose conv_done never arrives (timeout_err pulse).
module adc_scan_sequencer #(
  parameter int NUM_CH         = 16,
  parameter int CH_W           = 4,
  parameter int SAMPLE_W       = 12,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                adc_clk,
  input  logic                adc_rst_n,
  input  logic                scan_en,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [15:0]         frame_period,
  output logic [CH_W-1:0]     mux_sel,
  output logic                conv_start,
  input  logic                conv_done,
  input  logic [SAMPLE_W-1:0] conv_data,
  output logic [SAMPLE_W-1:0] adc_sample,
  output logic [CH_W-1:0]     adc_channel,
  output logic                adc_valid,
  output logic                frame_done,
  output logic                overrun,
  output logic                timeout_err
);

  // One cycle counter serves both the settle window and the conversion
  // watchdog, so it must reach the larger of the two limits.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, SETTLE, CONVERT, EMIT, WAIT_FRAME
  } state_t;

  state_t              r_state, w_nxt_state;
  logic [15:0]         r_cnt;
  logic [NUM_CH-1:0]   r_mask;
  logic [CH_W-1:0]     r_mux_sel;
  logic [CNT_W-1:0]    r_cyc;
  logic [SAMPLE_W-1:0] r_sample;
  logic [CH_W-1:0]     r_channel;
  logic                r_empty_fd;   // frame_done owed for an empty-mask frame
  logic                r_stop;       // scan_en dropped while a channel was in flight
  logic                r_skip;       // current EMIT follows a watchdog expiry

  logic              w_tick, w_busy, w_ovr, w_wd_expire;
  logic [NUM_CH-1:0] w_rem;
  logic              w_ld_mask, w_clr_bit, w_ld_sel, w_ld_sample;
  logic              w_set_empty_fd, w_set_skip, w_valid, w_fd_emit;

  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest = CH_W'(i);
  endfunction

  // Frame period counter: held at zero while disabled so the first enabled
  // cycle always ticks; periods of 0 and 1 both tick every cycle.
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n)                                          r_cnt <= '0;
    else if (!scan_en)                                       r_cnt <= '0;
    else if (frame_period <= 16'd1 || r_cnt >= frame_period - 16'd1) r_cnt <= '0;
    else                                                     r_cnt <= r_cnt + 16'd1;
  end

  assign w_tick = scan_en && (r_cnt == 16'd0);
  assign w_busy = (r_state == SELECT) || (r_state == SETTLE) ||
                  (r_state == CONVERT) || (r_state == EMIT);
  // Back-to-back mode ticks every cycle by design, so a busy tick is not a fault there.
  assign w_ovr  = w_tick && w_busy && (frame_period != 16'd0);
  assign w_rem  = r_mask & ~(NUM_CH'(1) << r_mux_sel);

`ifdef ADC_SEQ_TIMEOUT_EN
  assign w_wd_expire = (r_state == CONVERT) && (r_cyc == CNT_W'(TIMEOUT_CYCLES)) && !conv_done;
`else
  assign w_wd_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) r_state <= IDLE;
    else            r_state <= w_nxt_state;
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_nxt_state    = r_state;
    w_ld_mask      = 1'b0;
    w_clr_bit      = 1'b0;
    w_ld_sel       = 1'b0;
    w_ld_sample    = 1'b0;
    w_set_empty_fd = 1'b0;
    w_set_skip     = 1'b0;
    w_valid        = 1'b0;
    w_fd_emit      = 1'b0;
    case (r_state)
      IDLE, WAIT_FRAME: begin
        // The cycle carrying an empty-frame frame_done is not a start cycle,
        // which gives the every-other-cycle cadence in back-to-back mode.
        if (w_tick && !r_empty_fd) begin
          w_ld_mask = 1'b1;
          if (ch_mask == '0) begin
            w_set_empty_fd = 1'b1;
            w_nxt_state    = WAIT_FRAME;
          end else begin
            w_nxt_state    = SELECT;
          end
        end else if (!scan_en) begin
          w_nxt_state = IDLE;
        end
      end
      SELECT: begin
        w_ld_sel    = 1'b1;
        w_nxt_state = SETTLE;
      end
      SETTLE: begin
        if (r_cyc == CNT_W'(SETTLE_CYCLES - 1)) w_nxt_state = CONVERT;
      end
      CONVERT: begin
        // conv_done in the conv_start cycle belongs to no request of ours.
        if (r_cyc != '0 && conv_done) begin
          w_ld_sample = 1'b1;
          w_nxt_state = EMIT;
        end else if (w_wd_expire) begin
          w_set_skip  = 1'b1;
          w_nxt_state = EMIT;
        end
      end
      EMIT: begin
        w_valid   = !r_skip;
        w_clr_bit = 1'b1;
        if (!scan_en || r_stop) begin
          w_nxt_state = IDLE;
        end else if (w_rem != '0) begin
          w_nxt_state = SELECT;
        end else begin
          w_fd_emit   = 1'b1;
          w_nxt_state = WAIT_FRAME;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // Working mask, mux select, captured sample and sequencing flags
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_mask     <= '0;
      r_mux_sel  <= '0;
      r_cyc      <= '0;
      r_sample   <= '0;
      r_channel  <= '0;
      r_empty_fd <= 1'b0;
      r_stop     <= 1'b0;
      r_skip     <= 1'b0;
    end else begin
      if (w_nxt_state != r_state)        r_cyc <= '0;
      else if (r_cyc != CNT_W'(CNT_MAX)) r_cyc <= r_cyc + CNT_W'(1);
      r_empty_fd <= w_set_empty_fd;
      if (w_ld_mask)      r_mask <= ch_mask;
      else if (w_clr_bit) r_mask <= w_rem;
      if (w_ld_sel) r_mux_sel <= lowest(r_mask);
      if (w_ld_sample) begin
        r_sample  <= conv_data;
        r_channel <= r_mux_sel;
      end
      if (r_state == IDLE || r_state == WAIT_FRAME) r_stop <= 1'b0;
      else if (!scan_en)                            r_stop <= 1'b1;
      if (w_set_skip)            r_skip <= 1'b1;
      else if (r_state == EMIT)  r_skip <= 1'b0;
    end
  end

  assign mux_sel     = r_mux_sel;
  assign conv_start  = (r_state == CONVERT) && (r_cyc == '0);
  assign adc_sample  = r_sample;
  assign adc_channel = r_channel;
  assign adc_valid   = w_valid;
  assign frame_done  = w_fd_emit || r_empty_fd;
  assign overrun     = w_ovr;
  assign timeout_err = w_wd_expire;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Scoreboard bench for adc_scan_sequencer: stimulus pushes expected strobes,
// a negedge monitor pops and compares each adc_valid; timing checks use cycle stamps.
module tb_adc_scan_sequencer;
  logic        adc_clk = 1'b0, adc_rst_n = 1'b0, scan_en = 1'b0;
  logic [15:0] ch_mask = '0, frame_period = '0;
  logic        conv_done = 1'b0;
  logic [11:0] conv_data = '0;
  logic [3:0]  mux_sel, adc_channel;
  logic [11:0] adc_sample;
  logic        conv_start, adc_valid, frame_done, overrun, timeout_err;

  adc_scan_sequencer dut (
    .adc_clk(adc_clk), .adc_rst_n(adc_rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
    .frame_period(frame_period), .mux_sel(mux_sel), .conv_start(conv_start),
    .conv_done(conv_done), .conv_data(conv_data), .adc_sample(adc_sample),
    .adc_channel(adc_channel), .adc_valid(adc_valid), .frame_done(frame_done),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct { logic [3:0] ch; logic [11:0] d; logic fd; } exp_t;
  exp_t        exp_q[$];
  logic [11:0] dat_q[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_valid = 0, n_fd = 0, n_ovr = 0, n_cs = 0, n_to = 0;
  int t_cs = -1, t_v = -1, t_to = -1;
  bit mute_next = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] ch, input logic [11:0] d, input logic fd);
    exp_t e;
    e.ch = ch; e.d = d; e.fd = fd;
    exp_q.push_back(e);
    dat_q.push_back(d);
  endtask

  task automatic to_cycle(input int t);
    while (cyc < t) begin @(posedge adc_clk); #1; end
  endtask

  task automatic start(input logic [15:0] m, input logic [15:0] p, output int t);
    ch_mask = m; frame_period = p;
    @(posedge adc_clk); #1;
    scan_en = 1'b1;
    t = cyc;
  endtask

  // cycle stamp: during cycle k (after posedge k) cyc == k
  initial forever begin @(posedge adc_clk); cyc++; end

  // monitor / scoreboard
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge adc_clk);
      if (conv_start)  begin n_cs++; t_cs = cyc; end
      if (frame_done)  n_fd++;
      if (overrun)     n_ovr++;
      if (timeout_err) begin n_to++; t_to = cyc; end
      if (adc_valid) begin
        n_valid++; t_v = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL strobe: unexpected ch %0d data 0x%0h, expected none", adc_channel, adc_sample);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_ch", adc_channel, e.ch);
          chk("strobe_data", adc_sample, e.d);
          chk("strobe_frame_done", frame_done, e.fd);
        end
      end
    end
  end

  // ADC model: conv_done 10 cycles after conv_start, data from dat_q
  initial begin : adc
    logic [11:0] d;
    forever begin
      @(negedge adc_clk);
      if (conv_start) begin
        if (mute_next) mute_next = 1'b0;
        else begin
          d = (dat_q.size() != 0) ? dat_q.pop_front() : 12'h000;
          repeat (10) @(posedge adc_clk);
          #1 conv_done = 1'b1; conv_data = d;
          @(posedge adc_clk);
          #1 conv_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got expired, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int T, bv, bf, bo, bc, bt;
    repeat (3) @(posedge adc_clk); #1;
    chk("rst_mux_sel", mux_sel, 0);     chk("rst_conv_start", conv_start, 0);
    chk("rst_adc_sample", adc_sample, 0); chk("rst_adc_channel", adc_channel, 0);
    chk("rst_adc_valid", adc_valid, 0); chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);     chk("rst_timeout_err", timeout_err, 0);
    adc_rst_n = 1'b1;
    to_cycle(cyc + 2);

    // basic scan, two frames
    push(0, 12'hA5A, 0); push(2, 12'h3C3, 1); push(0, 12'hA5A, 0); push(2, 12'h3C3, 1);
    bv = n_valid; bf = n_fd;
    start(16'h0005, 16'd200, T);
    to_cycle(T + 7);   chk("basic_cs_latency", t_cs, T + 6);
    to_cycle(T + 36);  chk("basic_strobes", n_valid - bv, 2);
    chk("basic_fd_count", n_fd - bf, 1);
    chk("basic_hold_sample", adc_sample, 12'h3C3); chk("basic_hold_ch", adc_channel, 2);
    to_cycle(T + 207); chk("basic_frame2_cs", t_cs, T + 206);
    to_cycle(T + 236); chk("basic_strobes2", n_valid - bv, 4);
    chk("basic_fd_count2", n_fd - bf, 2);
    scan_en = 1'b0;

    // mask change during channel 0 conversion
    push(0, 12'h111, 0); push(2, 12'h222, 1); push(3, 12'h333, 1);
    bv = n_valid;
    start(16'h0005, 16'd200, T);
    to_cycle(T + 10);  ch_mask = 16'h0008;
    to_cycle(T + 36);  chk("mask_frame1", n_valid - bv, 2);
    to_cycle(T + 218); chk("mask_frame2", n_valid - bv, 3);
    chk("mask_frame2_cs", t_cs, T + 206);
    scan_en = 1'b0;

    // overrun with all 16 channels
    for (int i = 0; i < 16; i++) push(4'(i), 12'h100 + 12'(i), i == 15);
    bv = n_valid; bf = n_fd; bo = n_ovr;
    start(16'hFFFF, 16'd50, T);
    to_cycle(T + 273); chk("ovr_strobes", n_valid - bv, 16);
    chk("ovr_pulses", n_ovr - bo, 5); chk("ovr_fd", n_fd - bf, 1);
    push(0, 12'h200, 0);
    to_cycle(T + 307); chk("ovr_next_frame_cs", t_cs, T + 306);
    scan_en = 1'b0;
    to_cycle(T + 320); chk("ovr_abort_strobes", n_valid - bv, 17);
    chk("ovr_abort_no_fd", n_fd - bf, 1);

    // empty mask, back-to-back frames
    bv = n_valid; bc = n_cs; bo = n_ovr;
    start(16'h0000, 16'd0, T);
    to_cycle(T + 4);   bf = n_fd;
    to_cycle(T + 24);  chk("empty_fd_every_other", n_fd - bf, 10);
    chk("empty_no_conv", n_cs - bc, 0);
    push(0, 12'h011, 1); push(0, 12'h022, 1); push(0, 12'h033, 1);
    ch_mask = 16'h0001;
    to_cycle(T + 42);  chk("b2b_first_strobe", t_v, T + 41);
    to_cycle(T + 60);  chk("b2b_second_strobe", t_v, T + 59);
    to_cycle(T + 78);  chk("b2b_third_strobe", t_v, T + 77);
    scan_en = 1'b0;
    to_cycle(T + 80);  chk("b2b_strobes", n_valid - bv, 3);
    chk("b2b_no_overrun", n_ovr - bo, 0);

    // scan_en drop during channel 1 settle
    push(0, 12'h0AA, 0); push(1, 12'h0BB, 0);
    bv = n_valid; bf = n_fd; bc = n_cs;
    start(16'h0003, 16'd200, T);
    to_cycle(T + 20);  scan_en = 1'b0;
    to_cycle(T + 40);  chk("dis_strobes", n_valid - bv, 2);
    chk("dis_no_fd", n_fd - bf, 0); chk("dis_conv_count", n_cs - bc, 2);

    // reset mid-conversion
    dat_q.push_back(12'hFFF);
    bv = n_valid; bf = n_fd;
    start(16'h0004, 16'd200, T);
    to_cycle(T + 8);   chk("pre_rst_mux_sel", mux_sel, 2);
    adc_rst_n = 1'b0; scan_en = 1'b0;
    #1;
    chk("mid_rst_mux_sel", mux_sel, 0);       chk("mid_rst_conv_start", conv_start, 0);
    chk("mid_rst_adc_sample", adc_sample, 0); chk("mid_rst_adc_channel", adc_channel, 1'b0);
    chk("mid_rst_adc_valid", adc_valid, 0);   chk("mid_rst_frame_done", frame_done, 0);
    to_cycle(T + 12);  adc_rst_n = 1'b1;
    to_cycle(T + 40);  chk("rst_late_done_no_strobe", n_valid - bv, 0);
    chk("rst_no_fd", n_fd - bf, 0);

    // ADC never answers channel 4
    bv = n_valid; bt = n_to; bc = n_cs;
    mute_next = 1'b1;
`ifdef ADC_SEQ_TIMEOUT_EN
    push(5, 12'h5A5, 1);
    start(16'h0030, 16'd200, T);
    to_cycle(T + 72);  chk("to_cycle_stamp", t_to, T + 70);
    chk("to_pulses", n_to - bt, 1); chk("to_sample_unchanged", adc_sample, 0);
    chk("to_no_strobe", n_valid - bv, 0);
    to_cycle(T + 90);  chk("to_ch5_strobes", n_valid - bv, 1);
    chk("to_ch5_cs", t_cs, T + 77);
    scan_en = 1'b0;
`else
    start(16'h0030, 16'd200, T);
    to_cycle(T + 150); chk("stall_no_strobe", n_valid - bv, 0);
    chk("stall_no_timeout", n_to - bt, 0); chk("stall_one_conv", n_cs - bc, 1);
    chk("stall_timeout_low", timeout_err, 0);
    scan_en = 1'b0; adc_rst_n = 1'b0;
    to_cycle(T + 152); adc_rst_n = 1'b1;
`endif
    to_cycle(cyc + 2);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Scan controller in the adc_clk domain; drives the electrode analog mux and the SAR ADC front-end.
- Walks the enabled recording channels in ascending order once per frame.
- Delivers each conversion as the adc_sample / adc_channel / adc_valid stream consumed by neural_implant_top.
- Frame rate is set by a programmable period counter; overruns and stuck conversions are flagged.

Parameters:
- NUM_CH, 16, number of electrode channels; one ch_mask bit per channel.
- CH_W, 4, channel index width; must hold NUM_CH-1.
- SAMPLE_W, 12, ADC result width.
- SETTLE_CYCLES, 4, mux settling cycles between a mux_sel change and conv_start; ≥1.
- TIMEOUT_CYCLES, 64, conversion watchdog limit; used only with ADC_SEQ_TIMEOUT_EN.

Ports:
- adc_clk  in  1  sequencer clock.
- adc_rst_n  in  1  asynchronous active-low reset.
- scan_en  in  1  level; enables frame scanning.
- ch_mask  in  NUM_CH  channel enable mask; latched at frame start.
- frame_period  in  16  adc_clk cycles between frame starts; 0 = back-to-back frames.
- mux_sel  out  CH_W  analog mux select.
- conv_start  out  1  one-cycle ADC start pulse.
- conv_done  in  1  ADC result-valid pulse.
- conv_data  in  SAMPLE_W  ADC result; valid with conv_done.
- adc_sample  out  SAMPLE_W  captured result.
- adc_channel  out  CH_W  channel of adc_sample.
- adc_valid  out  1  one-cycle sample strobe.
- frame_done  out  1  one-cycle pulse after the last channel of a frame.
- overrun  out  1  one-cycle pulse when a frame tick is dropped.
- timeout_err  out  1  one-cycle pulse on watchdog expiry; tied 0 without the macro.

Behaviour:
- Reset: every output is 0, state = IDLE, frame counter = 0, latched mask = 0. Reset asserted mid-operation aborts immediately, with no partial strobe.
- States: IDLE, SELECT, SETTLE, CONVERT, EMIT, WAIT_FRAME.
- Frame counter:
  - Runs only while scan_en = 1; counts 0..frame_period-1, then wraps.
  - The frame tick fires on count==0.
  - scan_en rising zeroes the counter, so the first tick occurs on the first scan_en=1 cycle.
- IDLE or WAIT_FRAME with tick:
  - Latch ch_mask into the working mask.
  - Working mask ==0: pulse frame_done the next cycle and stay in WAIT_FRAME.
  - Otherwise go to SELECT.
- SELECT (1 cycle): mux_sel <= lowest set bit of the working mask, then go to SETTLE.
- SETTLE: exactly SETTLE_CYCLES cycles, then go to CONVERT.
- CONVERT:
  - conv_start=1 on the first cycle only.
  - conv_done is sampled from the following cycle onward; conv_done coincident with conv_start is ignored.
  - On conv_done, capture conv_data and go to EMIT.
- EMIT (1 cycle):
  - adc_valid=1 with adc_sample = captured data and adc_channel = mux_sel. adc_sample and adc_channel hold until the next EMIT.
  - Clear that bit in the working mask.
  - If bits remain and scan_en=1, go to SELECT.
  - If none remain, frame_done=1 in the same cycle, then go to WAIT_FRAME.
- Latency: SELECT entry to conv_start = SETTLE_CYCLES+1 cycles; conv_done to adc_valid = 1 cycle.
- frame_period=0: a tick is generated every cycle; the next frame starts the cycle after frame_done; overrun is never flagged.
- Overrun: a tick arriving in SELECT/SETTLE/CONVERT/EMIT pulses overrun and is dropped. The current frame completes; the next frame waits for the following tick.
- scan_en deassert:
  - In SELECT/SETTLE/CONVERT, the current channel completes through EMIT, then the block goes to IDLE without frame_done.
  - In WAIT_FRAME, go to IDLE next cycle.
  - ch_mask changes mid-frame have no effect until the next tick.

Optional Feature:
- Macro ADC_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counts CONVERT cycles after conv_start.
  - If conv_done is absent for TIMEOUT_CYCLES cycles, pulse timeout_err and skip to EMIT-equivalent bookkeeping: clear the mask bit, adc_valid stays 0, adc_sample is unchanged.
  - Sequencing then continues as normal.
- Undefined: no watchdog logic; CONVERT waits indefinitely; timeout_err is constant 0.

Test Plan:
- Basic scan: ch_mask=16'h0005, frame_period=200, SETTLE_CYCLES=4, ADC model returning conv_done 10 cycles after start with data 12'hA5A then 12'h3C3 → exactly two adc_valid strobes, (ch 0, A5A) then (ch 2, 3C3); conv_start 5 cycles after SELECT entry; frame_done coincident with the second strobe; frames repeat every 200 cycles.
- Mask update mid-frame: change ch_mask 0005→0008 during channel 0 conversion → channel 2 is still scanned this frame; the next frame scans only channel 3.
- Overrun: ch_mask=16'hFFFF, frame_period=50, ADC latency 10 → overrun pulse every frame; all 16 channels are still emitted in order, with the next frame starting on the following tick.
- Empty mask and back-to-back: ch_mask=0, frame_period=0 → frame_done every other cycle and no conv_start. Then ch_mask=16'h0001 → continuous channel-0 samples with no gap beyond the SELECT/SETTLE/CONVERT/EMIT sequence.
- Disable and reset:
  - Drop scan_en during SETTLE of channel 1 (mask 0003) → channel 1 is still emitted, no frame_done, then IDLE.
  - Assert adc_rst_n=0 mid-CONVERT → all outputs 0 immediately; a late conv_done after release produces no adc_valid.
- Timeout (macro defined, TIMEOUT_CYCLES=64): ADC never answers channel 4 (mask 0030) → timeout_err 64 cycles after conv_start, no strobe for channel 4, channel 5 sampled normally. Without the macro, the same stimulus stalls in CONVERT and timeout_err stays 0.
